// File: rtl/input_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : input_debouncer_pkg
// Purpose  : Shared FSM state encodings and width helper for input_debouncer.
// Revision : 1.0 - initial release
// ============================================================================
package input_debouncer_pkg;

  // Debounce FSM states; encodings are fixed so waveforms match other blocks
  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    CHK_HI = 2'd1,
    ST_HI  = 2'd2,
    CHK_LO = 2'd3
  } state_t;

  // Ceiling log2, used to size the qualification counter
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage : input_debouncer_pkg
`default_nettype wire

// File: rtl/input_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module   : input_debouncer_if
// Purpose  : Raw input and conditioned outputs of the debouncer.
// Revision : 1.0 - initial release
// ============================================================================
interface input_debouncer_if;
  logic din;
  logic dout;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  // Side that owns the raw pin and consumes the clean level
  modport master (
    output din,
    input  dout,
    input  rise_pulse,
    input  fall_pulse,
    input  busy
  );

  // The debouncer itself
  modport slave (
    input  din,
    output dout,
    output rise_pulse,
    output fall_pulse,
    output busy
  );
endinterface : input_debouncer_if
`default_nettype wire

// File: rtl/input_debouncer_sync_chain.sv
`default_nettype none
// ============================================================================
// Module   : sync_chain
// Purpose  : Reset-cleared flop chain bringing an asynchronous level into clk.
//            STAGES must be at least 2.
// Revision : 1.0 - initial release
// ============================================================================
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage;

  generate
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      if (i == 0) begin : g_first
        // First flop samples the raw asynchronous input
        always_ff @(posedge clk) begin
          if (reset) stage[0] <= 1'b0;
          else       stage[0] <= d;
        end
      end else begin : g_rest
        // Remaining flops give metastability time to resolve
        always_ff @(posedge clk) begin
          if (reset) stage[i] <= 1'b0;
          else       stage[i] <= stage[i-1];
        end
      end
    end
  endgenerate

  assign q = stage[STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : input_debouncer
// Purpose  : Synchronises a raw level, requires DEBOUNCE_CYCLES consecutive
//            equal samples before changing dout, and emits rise/fall pulses.
// Revision : 1.0 - initial release
// ============================================================================
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input_debouncer_if.slave    bus
);

  localparam int             CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             dout, dout_nx;
  logic             rise, rise_nx;
  logic             fall, fall_nx;
  logic             busy, busy_nx;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.din),
    .q     (s)
  );

  // State, counter and all outputs are registered together
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_LO;
      cnt   <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      dout  <= dout_nx;
      rise  <= rise_nx;
      fall  <= fall_nx;
      busy  <= busy_nx;
    end
  end

  // Next-state: qualify a candidate level; any disagreeing sample drops it
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dout_nx  = dout;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    case (state)
      ST_LO: begin
        if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nx = ST_HI;
            dout_nx  = 1'b1;
            rise_nx  = 1'b1;
            cnt_nx   = '0;
          end else begin
            state_nx = CHK_HI;
            cnt_nx   = CNT_ONE;
          end
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_nx = ST_LO;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = ST_HI;
          dout_nx  = 1'b1;
          rise_nx  = 1'b1;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      ST_HI: begin
        if (!s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nx = ST_LO;
            dout_nx  = 1'b0;
            fall_nx  = 1'b1;
            cnt_nx   = '0;
          end else begin
            state_nx = CHK_LO;
            cnt_nx   = CNT_ONE;
          end
        end
      end
      CHK_LO: begin
        if (s) begin
          state_nx = ST_HI;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = ST_LO;
          dout_nx  = 1'b0;
          fall_nx  = 1'b1;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nx = ST_LO;
        cnt_nx   = '0;
        dout_nx  = 1'b0;
      end
    endcase
    busy_nx = (state_nx == CHK_HI) || (state_nx == CHK_LO);
  end

  assign bus.dout       = dout;
  assign bus.rise_pulse = rise;
  assign bus.fall_pulse = fall;
  assign bus.busy       = busy;

endmodule : input_debouncer
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_debouncer
// Purpose  : Directed self-checking bench for input_debouncer, including a
//            downstream negative-edge D flip-flop fed by dout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_debouncer;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  input_debouncer_if dbg ();

  input_debouncer #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dbg)
  );

  // Downstream negative-edge capture stage
  logic q, qbar;
  always_ff @(negedge clk) begin
    q    <= dbg.dout;
    qbar <= ~dbg.dout;
  end

  // 20-unit clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic d, input logic r,
                            input logic f, input logic b);
    check({tag, ".dout"}, {31'd0, dbg.dout},       {31'd0, d});
    check({tag, ".rise"}, {31'd0, dbg.rise_pulse}, {31'd0, r});
    check({tag, ".fall"}, {31'd0, dbg.fall_pulse}, {31'd0, f});
    check({tag, ".busy"}, {31'd0, dbg.busy},       {31'd0, b});
  endtask

  // Look at the downstream flop just after its capture edge
  task automatic check_neg(input string tag, input logic exp_q);
    @(negedge clk);
    #1;
    check({tag, ".q"},    {31'd0, q},    {31'd0, exp_q});
    check({tag, ".qbar"}, {31'd0, qbar}, {31'd0, ~exp_q});
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset   = 1'b1;
    dbg.din = 1'b1;

    // 1: reset held with din=1
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    dbg.din = 1'b0;
    reset   = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // 2: clean rise, edges counted from first sampling of din=1
    dbg.din = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_outs($sformatf("rise_e%0d", e), (e >= 6), (e == 6), 1'b0,
                 (e >= 3 && e <= 5));
    end
    check_neg("neg_hi", 1'b1);

    // 4: clean fall from dout=1
    dbg.din = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_outs($sformatf("fall_e%0d", e), (e < 6), 1'b0, (e == 6),
                 (e >= 3 && e <= 5));
    end
    check_neg("neg_lo", 1'b0);

    // 3: high glitches of 1..3 cycles are rejected
    for (int len = 1; len <= 3; len++) begin
      dbg.din = 1'b1;
      for (int i = 0; i < len; i++) begin
        tick();
        check($sformatf("gl%0d_dout", len), {31'd0, dbg.dout}, 32'd0);
      end
      dbg.din = 1'b0;
      for (int i = 0; i < 6; i++) begin
        tick();
        check($sformatf("gl%0d_rise", len), {31'd0, dbg.rise_pulse}, 32'd0);
        check($sformatf("gl%0d_dout", len), {31'd0, dbg.dout},       32'd0);
      end
      check($sformatf("gl%0d_busy", len), {31'd0, dbg.busy}, 32'd0);
      check_neg($sformatf("gl%0d_neg", len), 1'b0);
    end

    // 5: reset in the middle of qualification (cnt=2 after edge 4)
    dbg.din = 1'b1;
    for (int e = 1; e <= 4; e++) tick();
    check("mid_busy", {31'd0, dbg.busy}, 32'd1);
    reset = 1'b1;
    tick();
    check_outs("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check_outs($sformatf("requal_e%0d", e), (e >= 6), (e == 6), 1'b0,
                 (e >= 3 && e <= 5));
    end
    check_neg("neg_requal", 1'b1);

    // Low bounce while high: brief drops must not reach dout or q
    dbg.din = 1'b0;
    tick();
    tick();
    dbg.din = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bounce_dout", {31'd0, dbg.dout},       32'd1);
      check("bounce_fall", {31'd0, dbg.fall_pulse}, 32'd0);
    end
    check_neg("neg_bounce", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_input_debouncer
`default_nettype wire
